// File: rtl/intr_ctrl.sv
// Priority interrupt controller: up to 8 level/edge sources, fixed lowest-index
// priority, request/service handshake with the core and EOI-based completion.
module intr_ctrl #(
  parameter int NUM_SRC = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               sel,
  input  logic [2:0]         addr,
  input  logic [31:0]        wdata,
  input  logic               wen,
  output logic [31:0]        rdata,
  input  logic [NUM_SRC-1:0] irq_src,
  output logic               int_req,
  output logic [2:0]         int_id,
  input  logic               int_ack
);

  localparam logic [2:0] ADDR_ENABLE   = 3'b000;
  localparam logic [2:0] ADDR_PENDING  = 3'b001;
  localparam logic [2:0] ADDR_EDGE_SEL = 3'b010;
  localparam logic [2:0] ADDR_CLAIM    = 3'b011;
  localparam logic [2:0] ADDR_EOI      = 3'b100;

  // Internal vectors are always 8 bits wide; bits at or above NUM_SRC stay 0.
  localparam logic [7:0] SRC_MASK = 8'((9'd1 << NUM_SRC) - 9'd1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_SERVICE = 2'd2
  } state_t;

  function automatic logic [2:0] lowest_idx(input logic [7:0] vec);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (vec[i]) begin
        idx = 3'(i);
      end else begin
        idx = idx;
      end
    end
    return idx;
  endfunction

  logic [7:0]  irq_ext_s;
  logic [7:0]  src_q;
  logic [7:0]  src_qq;
  logic [7:0]  enable_r;
  logic [7:0]  edge_sel_r;
  logic [7:0]  pending_r;
  logic [7:0]  pending_next_s;
  logic [7:0]  set_s;
  logic [7:0]  w1c_s;
  logic [7:0]  ack_clr_s;
  logic [7:0]  active_src_s;
  state_t      state_r;
  state_t      state_next_s;
  logic [2:0]  int_id_r;
  logic [2:0]  id_next_s;
  logic        int_req_r;
  logic [31:0] rdata_r;
  logic [31:0] rd_mux_s;
  logic        wr_en_s;
  logic        wr_enable_s;
  logic        wr_pending_s;
  logic        wr_edge_sel_s;
  logic        wr_eoi_s;
  logic        unused_wdata_s;

  assign wr_en_s        = sel & wen;
  assign wr_enable_s    = wr_en_s & (addr == ADDR_ENABLE);
  assign wr_pending_s   = wr_en_s & (addr == ADDR_PENDING);
  assign wr_edge_sel_s  = wr_en_s & (addr == ADDR_EDGE_SEL);
  assign wr_eoi_s       = wr_en_s & (addr == ADDR_EOI);
  assign unused_wdata_s = ^wdata[31:8];
  assign active_src_s   = pending_r & enable_r;

  assign rdata   = rdata_r;
  assign int_req = int_req_r;
  assign int_id  = int_id_r;

  // Zero-extend the source lines to the internal 8-bit width.
  always_comb begin
    irq_ext_s = 8'd0;
    irq_ext_s[NUM_SRC-1:0] = irq_src;
  end

  // Two-stage source sampling for synchronisation and edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      src_q  <= 8'd0;
      src_qq <= 8'd0;
    end else begin
      src_q  <= irq_ext_s & SRC_MASK;
      src_qq <= src_q;
    end
  end

  // Configuration registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      enable_r   <= 8'd0;
      edge_sel_r <= 8'd0;
    end else begin
      if (wr_enable_s) begin
        enable_r <= wdata[7:0] & SRC_MASK;
      end else begin
        enable_r <= enable_r;
      end
      if (wr_edge_sel_s) begin
        edge_sel_r <= wdata[7:0] & SRC_MASK;
      end else begin
        edge_sel_r <= edge_sel_r;
      end
    end
  end

  // Pending next-state: level bits track src_q, edge bits latch with set-over-clear.
  always_comb begin
    set_s = src_q & ~src_qq & edge_sel_r;
    if (wr_pending_s) begin
      w1c_s = wdata[7:0];
    end else begin
      w1c_s = 8'd0;
    end
    if ((state_r == ST_REQ) && int_ack) begin
      ack_clr_s = 8'd1 << int_id_r;
    end else begin
      ack_clr_s = 8'd0;
    end
    pending_next_s = ((edge_sel_r & ((pending_r & ~(w1c_s | ack_clr_s)) | set_s))
                     | (~edge_sel_r & src_q)) & SRC_MASK;
  end

  // Pending register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_r <= 8'd0;
    end else begin
      pending_r <= pending_next_s;
    end
  end

  // Request/service FSM next-state and id selection.
  always_comb begin
    state_next_s = state_r;
    id_next_s    = int_id_r;
    case (state_r)
      ST_IDLE: begin
        if (|active_src_s) begin
          state_next_s = ST_REQ;
          id_next_s    = lowest_idx(active_src_s);
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_REQ: begin
        if (int_ack) begin
          state_next_s = ST_SERVICE;
        end else begin
          state_next_s = ST_REQ;
        end
      end
      ST_SERVICE: begin
        if (wr_eoi_s && (wdata[2:0] == int_id_r)) begin
          state_next_s = ST_IDLE;
        end else begin
          state_next_s = ST_SERVICE;
        end
      end
      default: begin
        state_next_s = ST_IDLE;
        id_next_s    = 3'd0;
      end
    endcase
  end

  // FSM state, latched id and registered request output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= ST_IDLE;
      int_id_r  <= 3'd0;
      int_req_r <= 1'b0;
    end else begin
      state_r   <= state_next_s;
      int_id_r  <= id_next_s;
      int_req_r <= (state_next_s == ST_REQ);
    end
  end

  // Register read multiplexer.
  always_comb begin
    rd_mux_s = 32'd0;
    case (addr)
      ADDR_ENABLE:   rd_mux_s = {24'd0, enable_r};
      ADDR_PENDING:  rd_mux_s = {24'd0, pending_r};
      ADDR_EDGE_SEL: rd_mux_s = {24'd0, edge_sel_r};
      ADDR_CLAIM:    rd_mux_s = {(state_r != ST_IDLE), 28'd0, int_id_r};
      default:       rd_mux_s = 32'd0;
    endcase
  end

  // Read data register: loads while selected, holds otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_r <= 32'd0;
    end else if (sel) begin
      rdata_r <= rd_mux_s;
    end else begin
      rdata_r <= rdata_r;
    end
  end

endmodule

// File: tb/tb_intr_ctrl.sv
// Self-checking bench for intr_ctrl: scenario tasks with a scoreboard queue of
// expected register read values.
module tb_intr_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        sel;
  logic [2:0]  addr;
  logic [31:0] wdata;
  logic        wen;
  logic [31:0] rdata;
  logic [7:0]  irq_src;
  logic        int_req;
  logic [2:0]  int_id;
  logic        int_ack;

  int total = 0;
  int bad = 0;
  logic [31:0] exp_q[$];

  intr_ctrl #(.NUM_SRC(8)) dut (
    .clk(clk), .rst_n(rst_n), .sel(sel), .addr(addr), .wdata(wdata), .wen(wen),
    .rdata(rdata), .irq_src(irq_src), .int_req(int_req), .int_id(int_id),
    .int_ack(int_ack)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    @(negedge clk);
    sel = 1'b1; wen = 1'b1; addr = a; wdata = d;
    @(posedge clk);
    #1;
    sel = 1'b0; wen = 1'b0;
  endtask

  task automatic rd_pop(input logic [2:0] a, output logic [31:0] got, output logic [31:0] exp);
    @(negedge clk);
    sel = 1'b1; wen = 1'b0; addr = a;
    @(posedge clk);
    #1;
    got = rdata;
    sel = 1'b0;
    exp = exp_q.pop_front();
  endtask

  task automatic ack();
    @(negedge clk);
    int_ack = 1'b1;
    @(posedge clk);
    #1;
    int_ack = 1'b0;
  endtask

  task automatic pulse(input logic [7:0] m);
    @(negedge clk);
    irq_src = irq_src | m;
    @(negedge clk);
    irq_src = irq_src & ~m;
  endtask

  task automatic test_reset();
    logic [31:0] got, exp;
    rst_n = 1'b0; sel = 1'b0; wen = 1'b0; addr = 3'd0; wdata = 32'd0;
    irq_src = 8'd0; int_ack = 1'b0;
    #12;
    total++;
    if (int_req !== 1'b0 || int_id !== 3'd0 || rdata !== 32'd0) begin
      bad++;
      $display("FAIL reset_out: req=%b id=%0d rdata=%h want 0/0/0", int_req, int_id, rdata);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int a = 0; a < 4; a++) begin
      exp_q.push_back(32'd0);
      rd_pop(3'(a), got, exp);
      total++;
      if (got !== exp) begin
        bad++;
        $display("FAIL reset_reg%0d: got %h want %h", a, got, exp);
      end
    end
    ack();
    tick();
    exp_q.push_back(32'd0);
    rd_pop(3'd3, got, exp);
    total++;
    if (int_req !== 1'b0 || got !== exp) begin
      bad++;
      $display("FAIL idle_ack: req=%b claim=%h want 0/%h", int_req, got, exp);
    end
  endtask

  task automatic test_level_latency();
    logic [31:0] got, exp;
    wr(3'd0, 32'h1);
    wr(3'd2, 32'h0);
    @(negedge clk);
    irq_src[0] = 1'b1;
    tick();
    tick();
    total++;
    if (int_req !== 1'b0) begin
      bad++;
      $display("FAIL lvl_early: req=%b want 0", int_req);
    end
    tick();
    total++;
    if (int_req !== 1'b1 || int_id !== 3'd0) begin
      bad++;
      $display("FAIL lvl_req: req=%b id=%0d want 1/0", int_req, int_id);
    end
    ack();
    exp_q.push_back(32'h8000_0000);
    rd_pop(3'd3, got, exp);
    total++;
    if (int_req !== 1'b0 || got !== exp) begin
      bad++;
      $display("FAIL lvl_service: req=%b claim=%h want 0/%h", int_req, got, exp);
    end
    wr(3'd4, 32'd0);
    total++;
    if (int_req !== 1'b0) begin
      bad++;
      $display("FAIL lvl_eoi_now: req=%b want 0", int_req);
    end
    tick();
    total++;
    if (int_req !== 1'b1 || int_id !== 3'd0) begin
      bad++;
      $display("FAIL lvl_rereq: req=%b id=%0d want 1/0", int_req, int_id);
    end
    @(negedge clk);
    irq_src[0] = 1'b0;
    ack();
    tick();
    tick();
    wr(3'd4, 32'd0);
    tick();
    total++;
    if (int_req !== 1'b0) begin
      bad++;
      $display("FAIL lvl_quiet: req=%b want 0", int_req);
    end
  endtask

  task automatic test_level_w1c();
    logic [31:0] got, exp;
    wr(3'd0, 32'h0);
    @(negedge clk);
    irq_src = 8'h08;
    tick();
    tick();
    wr(3'd1, 32'h08);
    exp_q.push_back(32'h08);
    rd_pop(3'd1, got, exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL lvl_w1c_ignored: got %h want %h", got, exp);
    end
    irq_src = 8'h00;
    tick();
    tick();
    exp_q.push_back(32'h00);
    rd_pop(3'd1, got, exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL lvl_follow: got %h want %h", got, exp);
    end
  endtask

  task automatic test_edge_priority();
    logic [31:0] got, exp;
    wr(3'd0, 32'hFF);
    wr(3'd2, 32'hFF);
    pulse(8'h24);
    tick();
    tick();
    total++;
    if (int_req !== 1'b1 || int_id !== 3'd2) begin
      bad++;
      $display("FAIL prio_first: req=%b id=%0d want 1/2", int_req, int_id);
    end
    exp_q.push_back(32'h24);
    rd_pop(3'd1, got, exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL prio_pending: got %h want %h", got, exp);
    end
    ack();
    exp_q.push_back(32'h8000_0002);
    rd_pop(3'd3, got, exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL prio_claim: got %h want %h", got, exp);
    end
    wr(3'd4, 32'd2);
    tick();
    total++;
    if (int_req !== 1'b1 || int_id !== 3'd5) begin
      bad++;
      $display("FAIL prio_second: req=%b id=%0d want 1/5", int_req, int_id);
    end
    ack();
    wr(3'd4, 32'd5);
    exp_q.push_back(32'h00);
    rd_pop(3'd1, got, exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL prio_end_pending: got %h want %h", got, exp);
    end
  endtask

  task automatic test_eoi_mismatch();
    logic [31:0] got, exp;
    pulse(8'h04);
    tick();
    tick();
    ack();
    wr(3'd4, 32'd3);
    exp_q.push_back(32'h8000_0002);
    rd_pop(3'd3, got, exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL eoi_bad_claim: got %h want %h", got, exp);
    end
    pulse(8'h40);
    tick();
    tick();
    tick();
    total++;
    if (int_req !== 1'b0) begin
      bad++;
      $display("FAIL svc_no_req: req=%b want 0", int_req);
    end
    exp_q.push_back(32'h40);
    rd_pop(3'd1, got, exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL svc_accum: got %h want %h", got, exp);
    end
    wr(3'd4, 32'd2);
    exp_q.push_back(32'h0000_0002);
    rd_pop(3'd3, got, exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL eoi_good_claim: got %h want %h", got, exp);
    end
    total++;
    if (int_req !== 1'b1 || int_id !== 3'd6) begin
      bad++;
      $display("FAIL eoi_next_req: req=%b id=%0d want 1/6", int_req, int_id);
    end
    ack();
    wr(3'd4, 32'd6);
    tick();
  endtask

  task automatic test_set_wins();
    logic [31:0] got, exp;
    wr(3'd0, 32'h0);
    pulse(8'h10);
    tick();
    tick();
    exp_q.push_back(32'h10);
    rd_pop(3'd1, got, exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL edge_set: got %h want %h", got, exp);
    end
    wr(3'd1, 32'h10);
    exp_q.push_back(32'h00);
    rd_pop(3'd1, got, exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL edge_w1c: got %h want %h", got, exp);
    end
    @(negedge clk);
    irq_src = 8'h10;
    @(negedge clk);
    sel = 1'b1; wen = 1'b1; addr = 3'd1; wdata = 32'h10; irq_src = 8'h00;
    tick();
    sel = 1'b0; wen = 1'b0;
    exp_q.push_back(32'h10);
    rd_pop(3'd1, got, exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL set_wins: got %h want %h", got, exp);
    end
    wr(3'd1, 32'h10);
  endtask

  task automatic test_addr_map();
    logic [31:0] got, exp;
    for (int a = 5; a < 8; a++) begin
      wr(3'(a), 32'hFFFF_FFFF);
    end
    for (int a = 4; a < 8; a++) begin
      exp_q.push_back(32'd0);
      rd_pop(3'(a), got, exp);
      total++;
      if (got !== exp) begin
        bad++;
        $display("FAIL addr%0d_zero: got %h want %h", a, got, exp);
      end
    end
    wr(3'd0, 32'hFFFF_FFFF);
    exp_q.push_back(32'h0000_00FF);
    rd_pop(3'd0, got, exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL enable_mask: got %h want %h", got, exp);
    end
    wr(3'd2, 32'hFFFF_FFFF);
    exp_q.push_back(32'h0000_00FF);
    rd_pop(3'd2, got, exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL edgesel_mask: got %h want %h", got, exp);
    end
  endtask

  task automatic test_hold_and_reset();
    logic [31:0] got, exp;
    wr(3'd0, 32'h02);
    pulse(8'h02);
    tick();
    tick();
    total++;
    if (int_req !== 1'b1 || int_id !== 3'd1) begin
      bad++;
      $display("FAIL hold_req: req=%b id=%0d want 1/1", int_req, int_id);
    end
    wr(3'd0, 32'h00);
    tick();
    wr(3'd4, 32'd1);
    total++;
    if (int_req !== 1'b1 || int_id !== 3'd1) begin
      bad++;
      $display("FAIL hold_stable: req=%b id=%0d want 1/1", int_req, int_id);
    end
    ack();
    exp_q.push_back(32'h8000_0001);
    rd_pop(3'd3, got, exp);
    total++;
    if (int_req !== 1'b0 || got !== exp) begin
      bad++;
      $display("FAIL hold_service: req=%b claim=%h want 0/%h", int_req, got, exp);
    end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    total++;
    if (int_req !== 1'b0 || int_id !== 3'd0 || rdata !== 32'd0) begin
      bad++;
      $display("FAIL async_reset: req=%b id=%0d rdata=%h want 0/0/0", int_req, int_id, rdata);
    end
    #10;
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.push_back(32'd0);
    rd_pop(3'd3, got, exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL post_reset_claim: got %h want %h", got, exp);
    end
    exp_q.push_back(32'd0);
    rd_pop(3'd2, got, exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL post_reset_edgesel: got %h want %h", got, exp);
    end
  endtask

  initial begin
    test_reset();
    test_level_latency();
    test_level_w1c();
    test_edge_priority();
    test_eoi_mismatch();
    test_set_wins();
    test_addr_map();
    test_hold_and_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/intr_ctrl.md
INTR_CTRL -- requirements
Module: intr_ctrl

Interface
REQ-001 Parameter NUM_SRC, default 8, number of interrupt sources (1..8); source 0 is the system timer irq.
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 sel  input  1  register block select.
REQ-005 addr  input  3  register address: 000=ENABLE, 001=PENDING, 010=EDGE_SEL, 011=CLAIM, 100=EOI.
REQ-006 wdata  input  32  register write data.
REQ-007 wen  input  1  write enable; a write takes effect only when sel=1.
REQ-008 rdata  output  32  registered read data.
REQ-009 irq_src  input  NUM_SRC  interrupt source lines; bit 0 is the system timer irq.
REQ-010 int_req  output  1  interrupt request to core.
REQ-011 int_id  output  3  id of the requested or in-service source.
REQ-012 int_ack  input  1  core accepts the request.

Function
REQ-013 irq_src SHALL be registered into src_q every cycle; edge detection SHALL use src_q and its one-cycle-delayed copy src_qq.
REQ-014 ENABLE[NUM_SRC-1:0] SHALL be read/write; all other ENABLE bits SHALL be read-only 0.
REQ-015 EDGE_SEL[i]=1 SHALL select rising-edge mode for source i; EDGE_SEL[i]=0 SHALL select level mode; only bits below NUM_SRC are writable.
REQ-016 In level mode, PENDING[i] SHALL equal src_q[i], updated every cycle; W1C writes to a level-mode bit SHALL be ignored.
REQ-017 In edge mode, PENDING[i] SHALL be set by src_q[i]=1 with src_qq[i]=0, cleared by writing 1 to PENDING bit i, and cleared on int_ack for id i.
REQ-018 If an edge-mode set event and a clear event (W1C or ack) hit the same bit in the same cycle, set SHALL win.
REQ-019 FSM states SHALL be IDLE, REQ and SERVICE.
REQ-020 In IDLE, if (PENDING & ENABLE) is nonzero, the FSM SHALL latch the lowest set index into int_id and enter REQ.
REQ-021 int_req SHALL be 1 exactly while the FSM is in REQ.
REQ-022 In REQ, int_id SHALL be held stable until int_ack=1, even if that source's pending or enable bit drops.
REQ-023 int_ack=1 in REQ SHALL move the FSM to SERVICE; int_ack in IDLE or SERVICE SHALL be ignored.
REQ-024 In SERVICE, no new request SHALL be raised; pending bits SHALL keep accumulating.
REQ-025 A write to EOI with wdata[2:0]==int_id in SERVICE SHALL return the FSM to IDLE.
REQ-026 A mismatched EOI write, or any EOI write outside SERVICE, SHALL be ignored.
REQ-027 CLAIM reads SHALL return {active, 28'b0, int_id}, where active=1 in REQ or SERVICE; CLAIM writes SHALL be ignored.
REQ-028 EOI reads SHALL return 0; undefined addresses SHALL read 0 and ignore writes.
REQ-029 rdata SHALL load the addressed register on each rising edge when sel=1 and SHALL hold its value when sel=0; read data is therefore valid one cycle after addr is presented.
REQ-030 Latency: with src_q high after edge T and the source enabled in IDLE, PENDING SHALL be set after edge T+1 and int_req SHALL be high after edge T+2.
REQ-031 After an EOI in the cycle ending at edge E, the next request SHALL be evaluated in IDLE and int_req SHALL be high no earlier than after edge E+1.

Reset
REQ-032 While rst_n=0, ENABLE, PENDING, EDGE_SEL, src_q, src_qq, int_id and rdata SHALL be 0, int_req SHALL be 0, and the FSM SHALL be in IDLE, taking effect immediately (asynchronously).
REQ-033 Reset asserted in REQ or SERVICE SHALL drop int_req immediately and discard the in-service id.

Verification
REQ-034 Write ENABLE=0x01, EDGE_SEL=0, then hold irq_src[0]=1 -> int_req=1 with int_id=0 two cycles after sampling; int_ack -> SERVICE; EOI wdata=0 -> IDLE, then int_req re-asserts because the level is still high.
REQ-035 Set ENABLE=0xFF and EDGE_SEL=0xFF, pulse irq_src bits 5 and 2 in the same cycle -> int_id=2 first; after ack and EOI=2 -> int_id=5; PENDING reads 0x00 at the end.
REQ-036 In SERVICE for id 2, write EOI=3 -> CLAIM still reads 0x80000002 and no new request is raised; then write EOI=2 -> CLAIM reads 0x00000002 (active=0).
REQ-037 In edge mode, W1C PENDING bit 4 in the same cycle as a new rising edge on irq_src[4] -> PENDING[4]=1 (set wins).
REQ-038 In REQ with int_id=1, clear ENABLE bit 1 -> int_req and int_id=1 stay until int_ack; asserting rst_n=0 mid-SERVICE -> int_req=0 and CLAIM reads 0.
REQ-039 Reads of addr 100, 101, 110 and 111 -> rdata=0; a write to ENABLE of 0xFFFFFFFF with NUM_SRC=8 -> ENABLE reads 0x000000FF.
